fugue_load_sequencer: RTL and testbench
=======================================

Name: fugue_load_sequencer

Overview:
- Upstream feeder for fugue_top.
- Accepts a message as 32-bit words on a valid/ready stream and issues the one-cycle init pulse to the core.
- Splits each word into 16-bit load beats (MSB half first), zero-masks the unused bytes of the final word, and appends the 64-bit message bit length as four trailing beats.
- Drives the core's init/load/idata inputs and consumes its ack.

Parameters:
- WORDSIZE, 32, message word width; the only supported value.
- IOSIZE, 16, core load beat width; WORDSIZE = 2*IOSIZE.
- LEN_W, 64, bit-length counter width; emitted as LEN_W/IOSIZE beats.
- TIMEOUT, 255, maximum cycles load may stay high without ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a new message; ignored unless in IDLE.
- in_valid  in  1  word available.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_data  in  32  message word, big-endian (byte 0 = bits 31:24).
- in_last  in  1  word is the final message word.
- in_bytes  in  3  valid bytes in the last word, 0..4; ignored when in_last=0.
- ack  in  1  core accepts the current beat.
- init  out  1  one-cycle init pulse to the core.
- load  out  1  beat valid to the core.
- idata  out  16  beat data to the core.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the last length beat is accepted.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: the FSM enters IDLE. init, load, idata, in_ready, busy, done and err are all 0. The word register and bit counter are 0. Reset applies mid-message with no further beats, and the message is abandoned.
- Beat transfer: a beat transfers on a rising edge where load=1 and ack=1. load and idata are registered and stay stable until ack. A beat may complete in the cycle load rises if ack is already high.
- FSM states:
  - IDLE: on start, go to INIT and clear err.
  - INIT: init=1 for exactly one cycle, bit counter cleared, then go to WAIT_WORD.
  - WAIT_WORD: in_ready=1, load=0. On in_valid, latch the word (masked) and add to the bit counter: +32 for a non-last word, +8*in_bytes for a last word.
    - If in_last=1 and in_bytes=0, go to LEN.
    - Otherwise go to LOAD_HI.
  - LOAD_HI: load=1, idata=word[31:16]. On ack, go to LOAD_LO.
  - LOAD_LO: load=1, idata=word[15:0]. On ack, go to LEN if the word was last, else WAIT_WORD.
  - LEN: load=1. Send four beats of the bit counter, [63:48] first through [15:0] last, using a 2-bit index. On ack of index 3, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Last-word masking: bytes at index >= in_bytes are forced to 0. in_bytes values 5..7 are treated as 4.
- Bit counter: LEN_W bits, wraps modulo 2^64 with no overflow flag.
- in_ready is combinational from the state. A word offered outside WAIT_WORD stays pending upstream.
- start while busy is ignored. start and a reset edge together: reset wins.
- Latency:
  - start to init: 1 cycle.
  - Accepted word to first load: 1 cycle.
  - Zero ack-wait: 2 cycles per word, 4 cycles for the length.

Optional Feature:
- Macro: FUGUE_LOAD_TIMEOUT_EN.
- When defined:
  - A counter increments each cycle load=1 and ack=0, and clears on any transfer or when load=0.
  - When the counter reaches TIMEOUT: err is set (sticky until the next accepted start), load drops, and the FSM returns to IDLE without pulsing done.
- When not defined: no counter is built, the FSM waits for ack indefinitely, and err is tied to 0.

Test Plan:
- 3-byte message: start; one word in_data=0x61626300, in_last=1, in_bytes=3; ack always high -> init pulse, then beats 0x6162, 0x6300, 0x0000, 0x0000, 0x0000, 0x0018; done 1 cycle after the final beat; busy drops with done.
- Empty message: start; in_last=1, in_bytes=0 -> no data beats; beats 0x0000 x3 then 0x0000; done.
- Masking with stalls: two words 0x01020304 (not last) then 0xAABBCCDD (in_last=1, in_bytes=1); ack held low 3 cycles per beat -> beats 0x0102, 0x0304, 0xAA00, 0x0000, then length 0x0000, 0x0000, 0x0000, 0x0028; idata stays stable across each stall.
- Reset mid-operation: assert rst while in LOAD_LO -> load=0, busy=0, in_ready=0 immediately; a following start restarts cleanly with an init pulse.
- Start while busy: start pulse during LEN -> ignored, no second init pulse, done occurs once.
- Timeout: with FUGUE_LOAD_TIMEOUT_EN and TIMEOUT=8, ack stuck at 0 -> err=1 after 8 load-high cycles, load=0, no done; the next start clears err. Without the macro, load stays high and err=0.

Source files
------------

// File: rtl/fugue_load_sequencer.sv
// Feeds a 32-bit word stream into the fugue core as 16-bit load beats, then the 64-bit bit length.
// Optional macro FUGUE_LOAD_TIMEOUT_EN adds a load-without-ack watchdog that sets the sticky err flag.
module fugue_load_sequencer #(
    parameter int WORDSIZE = 32,
    parameter int IOSIZE   = 16,
    parameter int LEN_W    = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                in_last,
    input  logic [2:0]          in_bytes,
    input  logic                ack,
    output logic                init,
    output logic                load,
    output logic [IOSIZE-1:0]   idata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int NBYTES    = WORDSIZE / 8;
    localparam int LEN_BEATS = LEN_W / IOSIZE;
    localparam int IDX_W     = $clog2(LEN_BEATS);

    if (WORDSIZE != 2 * IOSIZE || LEN_W % IOSIZE != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("fugue_load_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_WORD,
        S_LOAD_HI,
        S_LOAD_LO,
        S_LEN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORDSIZE-1:0] word_q, word_d;
    logic                last_q, last_d;
    logic [LEN_W-1:0]    bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                load_q, load_d;
    logic [IOSIZE-1:0]   idata_q, idata_d;

    logic [2:0]          nb_eff;
    logic [WORDSIZE-1:0] masked;
    logic [5:0]          add_bits;
    logic                xfer;
    logic [LEN_W-1:0]    len_shift;

`ifdef FUGUE_LOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            timeout_hit;
`endif

    assign xfer = load_q & ack;

    always_comb begin
        nb_eff   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
        masked   = in_data;
        for (int b = 0; b < NBYTES; b++) begin
            if (in_last && b >= int'(nb_eff)) begin
                masked[WORDSIZE-1-8*b -: 8] = 8'h00;
            end
        end
        add_bits = in_last ? {nb_eff, 3'b000} : 6'(WORDSIZE);

        state_d  = state_q;
        word_d   = word_q;
        last_d   = last_q;
        bitcnt_d = bitcnt_q;
        idx_d    = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                bitcnt_d = '0;
                idx_d    = '0;
                state_d  = S_WAIT_WORD;
            end
            S_WAIT_WORD: begin
                if (in_valid) begin
                    word_d   = masked;
                    last_d   = in_last;
                    bitcnt_d = bitcnt_q + LEN_W'(add_bits);
                    idx_d    = '0;
                    state_d  = (in_last && nb_eff == 3'd0) ? S_LEN : S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (xfer) state_d = S_LOAD_LO;
            end
            S_LOAD_LO: begin
                if (xfer) state_d = last_q ? S_LEN : S_WAIT_WORD;
            end
            S_LEN: begin
                if (xfer) begin
                    if (idx_q == IDX_W'(LEN_BEATS - 1)) state_d = S_DONE;
                    else                                idx_d   = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FUGUE_LOAD_TIMEOUT_EN
        // The watchdog only counts cycles where a beat is offered and refused.
        err_d       = err_q;
        timeout_hit = load_q && !ack && (to_cnt_q == TO_W'(TIMEOUT - 1));
        to_cnt_d    = (load_q && !ack) ? to_cnt_q + 1'b1 : '0;
        if (state_q == S_IDLE && start) err_d = 1'b0;
        if (timeout_hit) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end
`endif

        // Beat outputs are registered, so they are derived from the next-state values.
        load_d    = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO) || (state_d == S_LEN);
        len_shift = bitcnt_d >> (IOSIZE * (LEN_BEATS - 1 - int'(idx_d)));
        unique case (state_d)
            S_LOAD_HI: idata_d = word_d[WORDSIZE-1:IOSIZE];
            S_LOAD_LO: idata_d = word_d[IOSIZE-1:0];
            S_LEN:     idata_d = len_shift[IOSIZE-1:0];
            default:   idata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            last_q   <= 1'b0;
            bitcnt_q <= '0;
            idx_q    <= '0;
            load_q   <= 1'b0;
            idata_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            last_q   <= last_d;
            bitcnt_q <= bitcnt_d;
            idx_q    <= idx_d;
            load_q   <= load_d;
            idata_q  <= idata_d;
        end
    end

`ifdef FUGUE_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready = (state_q == S_WAIT_WORD);
    assign init     = (state_q == S_INIT);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign load     = load_q;
    assign idata    = idata_q;

endmodule

// File: tb/tb_fugue_load_sequencer.sv
// Self-checking bench for fugue_load_sequencer: directed vector table, corner sequences, random messages vs. a byte-level model.
module tb_fugue_load_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, ack;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_ready, init, load, busy, done, err;
  logic [15:0] idata;

  fugue_load_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .ack(ack),
    .init(init), .load(load), .idata(idata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endfunction

  typedef struct packed {
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [2:0]   nb;
    int           stall;
    int           nexp;
    logic [127:0] ex;
  } vec_t;

  function automatic vec_t mk(int nw, logic [31:0] w0, logic [31:0] w1, logic [2:0] nb,
                              int stall, int nexp, logic [127:0] ex);
    vec_t v;
    v.nw = nw; v.w0 = w0; v.w1 = w1; v.nb = nb; v.stall = stall; v.nexp = nexp; v.ex = ex;
    return v;
  endfunction

  vec_t        vecs[5];
  logic [15:0] exp_q[$];
  logic [31:0] msg_w[8];
  int          msg_n;
  logic [2:0]  msg_nb;
  int          ack_mode;   // >=0: stall cycles per beat, -1 random, -2 stuck low, -3 manual
  int          stall_cnt = 0;
  int          init_cnt = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  bit          pend = 1'b0;
  logic [15:0] pend_data = '0;

  // Monitor: beats, stability under stall, init/done pulse counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (init) init_cnt++;
      if (done) done_cnt++;
      if (load && pend) check("idata_stable", idata, pend_data);
      if (load && ack) begin
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_beat: got beat 0x%0h expected none", idata);
          end else begin
            check("beat", idata, exp_q.pop_front());
          end
        end
        pend = 1'b0;
        stall_cnt = 0;
      end else if (load) begin
        pend = 1'b1;
        pend_data = idata;
        stall_cnt++;
      end else begin
        pend = 1'b0;
        stall_cnt = 0;
      end
    end else begin
      pend = 1'b0;
      stall_cnt = 0;
    end
  end

  // Ack driver.
  always @(posedge clk) begin
    #1;
    if (ack_mode >= 0)       ack = (stall_cnt >= ack_mode);
    else if (ack_mode == -1) ack = (stall_cnt >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
    else if (ack_mode == -2) ack = 1'b0;
  end

  // Reference model: bytes of the message, zero-padded, split into beats, then the bit length.
  function automatic void build_model();
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [63:0] len;
    int nbe, total, nwords;
    nbe = (msg_nb > 3'd4) ? 4 : int'(msg_nb);
    for (int i = 0; i < msg_n; i++) begin
      w = msg_w[i];
      for (int b = 0; b < 4; b++) begin
        if (i < msg_n - 1 || b < nbe) bytes.push_back(w[31-8*b -: 8]);
        else                          bytes.push_back(8'h00);
      end
    end
    total  = 4 * (msg_n - 1) + nbe;
    nwords = msg_n - 1 + ((nbe > 0) ? 1 : 0);
    exp_q.delete();
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back({bytes[4*i], bytes[4*i+1]});
      exp_q.push_back({bytes[4*i+2], bytes[4*i+3]});
    end
    len = 64'(total) * 64'd8;
    for (int j = 3; j >= 0; j--) exp_q.push_back(len[16*j +: 16]);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offers one word at a negedge and waits for in_ready; returns with the caller at a negedge.
  task automatic offer_word(input logic [31:0] d, input logic last, input logic [2:0] nb, output bit ok);
    int k = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    ok = in_ready;
    if (!ok) begin
      n_chk++;
      n_err++;
      $display("FAIL word_accept: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_msg(input bit inject_start, input bit gaps);
    bit ok;
    int k;
    init_cnt = 0; done_cnt = 0; mon_en = 1'b1;
    pulse_start();
    @(negedge clk);
    check("init_pulse", init, 1);
    check("err_after_start", err, 0);
    for (int i = 0; i < msg_n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      offer_word(msg_w[i], i == msg_n - 1,
                 (i == msg_n - 1) ? msg_nb : 3'($urandom_range(0, 7)), ok);
      if (!ok) return;
      check("load_after_word", load, 1);
    end
    if (inject_start) begin
      k = 0;
      while (exp_q.size() > 2 && k < 2000) begin @(negedge clk); k++; end
      pulse_start();
    end
    k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    check("done_seen", done, 1);
    check("beats_before_done", exp_q.size(), 0);
    check("busy_with_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    repeat (2) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("init_count", init_cnt, 1);
    check("err_clean", err, 0);
    mon_en = 1'b0;
  endtask

  task automatic load_vec(input int v);
    logic [127:0] ex;
    msg_n = vecs[v].nw; msg_w[0] = vecs[v].w0; msg_w[1] = vecs[v].w1; msg_nb = vecs[v].nb;
    ack_mode = vecs[v].stall;
    ex = vecs[v].ex;
    exp_q.delete();
    for (int j = 0; j < vecs[v].nexp; j++) exp_q.push_back(ex[127-16*j -: 16]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    vecs[0] = mk(1, 32'h61626300, 32'h0, 3'd3, 0, 6,
                 {16'h6162, 16'h6300, 16'h0000, 16'h0000, 16'h0000, 16'h0018, 32'h0});
    vecs[1] = mk(1, 32'h12345678, 32'h0, 3'd0, 0, 4, {64'h0, 64'h0});
    vecs[2] = mk(2, 32'h01020304, 32'hAABBCCDD, 3'd1, 3, 8,
                 {16'h0102, 16'h0304, 16'hAA00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0028});
    vecs[3] = mk(1, 32'hDEADBEEF, 32'h0, 3'd6, 1, 6,
                 {16'hDEAD, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 32'h0});
    vecs[4] = mk(2, 32'h11223344, 32'h55667788, 3'd2, 2, 8,
                 {16'h1122, 16'h3344, 16'h5566, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0030});

    // Clock/reset
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
    ack = 1'b0; ack_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_init", init, 0);
    check("rst_load", load, 0);
    check("rst_idata", idata, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_msg(1'b0, 1'b0);
    end

    // Start while busy in the length phase
    msg_n = 1; msg_w[0] = 32'h41424344; msg_nb = 3'd4; ack_mode = 1;
    build_model();
    run_msg(1'b1, 1'b0);

    // Reset while in LOAD_LO, then a clean restart
    mon_en = 1'b0; ack_mode = -3; ack = 1'b0;
    pulse_start();
    @(negedge clk);
    offer_word(32'hCAFEF00D, 1'b0, 3'd0, ok);
    check("hi_beat", idata, 16'hCAFE);
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    @(negedge clk);
    check("lo_beat", idata, 16'hF00D);
    check("lo_load", load, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_load", load, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    load_vec(0);
    run_msg(1'b0, 1'b0);

    // Ack stuck low
    mon_en = 1'b0; ack_mode = -2; done_cnt = 0;
    pulse_start();
    @(negedge clk);
    offer_word(32'h11111111, 1'b0, 3'd0, ok);
`ifdef FUGUE_LOAD_TIMEOUT_EN
    n = 0;
    while (load && n < 100) begin n++; @(negedge clk); end
    check("timeout_cycles", n, TO);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", done_cnt, 0);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    load_vec(1);
    run_msg(1'b0, 1'b0);
`else
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (load) n++;
      @(negedge clk);
    end
    check("stuck_load_held", n, 20);
    check("stuck_err_zero", err, 0);
    check("stuck_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
`endif

    // Random messages against the model
    for (int r = 0; r < 40; r++) begin
      msg_n = $urandom_range(1, 5);
      for (int i = 0; i < msg_n; i++) msg_w[i] = $urandom;
      msg_nb = 3'($urandom_range(0, 7));
      ack_mode = -1;
      build_model();
      run_msg(1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
